// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the fetch PC and issues pipelined
// requests on a req/gnt/rvalid port. Returned words land in an in-order
// prefetch queue that is presented to ID as {pc, instr} with valid/ready.
// A redirect flushes the queue and arranges for stale in-flight responses to
// be dropped through a discard counter.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    redirect_i,
  input  logic [XLEN-1:0]         redirect_pc_i,
  output logic                    imem_req_o,
  output logic [XLEN-1:0]         imem_addr_o,
  input  logic                    imem_gnt_i,
  input  logic                    imem_rvalid_i,
  input  logic [31:0]             imem_rdata_i,
  output logic                    id_valid_o,
  input  logic                    id_ready_i,
  output logic [XLEN-1:0]         id_pc_o,
  output logic [31:0]             id_instr_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [AW-1:0]    fill_q, fill_d;       // oldest allocated-but-unfilled entry
  logic [CW-1:0]    count_q, count_d;     // allocated entries (filled + pending)
  logic [CW-1:0]    pending_q, pending_d; // allocated entries still awaiting data
  logic [CW-1:0]    discard_q, discard_d; // stale responses still to be dropped
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [XLEN-1:0]  epc_q [DEPTH];
  logic [XLEN-1:0]  epc_d [DEPTH];
  logic [31:0]      einstr_q [DEPTH];
  logic [31:0]      einstr_d [DEPTH];

  logic alloc, pop, fill, drop, has_target;

  // Handshake outputs are pure functions of registered state and this cycle's redirect.
  assign imem_req_o  = (state_q == RUN) && !redirect_i && (count_q < CW'(DEPTH));
  assign imem_addr_o = pc_q;
  assign id_valid_o  = filled_q[head_q] && !redirect_i;
  assign id_pc_o     = epc_q[head_q];
  assign id_instr_o  = einstr_q[head_q];
  assign count_o     = count_q;

  assign alloc      = imem_req_o && imem_gnt_i;
  assign pop        = id_valid_o && id_ready_i;
  assign has_target = (discard_q != '0) || (pending_q != '0);
  assign drop       = imem_rvalid_i && (discard_q != '0);
  assign fill       = imem_rvalid_i && (discard_q == '0) && (pending_q != '0);

  // Next-state for FSM, PC, queue pointers, counters and entry storage.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    head_d    = head_q;
    tail_d    = tail_q;
    fill_d    = fill_q;
    count_d   = count_q;
    pending_d = pending_q;
    discard_d = discard_q;
    filled_d  = filled_q;
    epc_d     = epc_q;
    einstr_d  = einstr_q;

    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (!start_i && !redirect_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (redirect_i) begin
      // Every unfilled entry becomes a stale response; an rvalid this cycle
      // is the oldest of those and is consumed right now.
      pc_d      = {redirect_pc_i[XLEN-1:2], 2'b00};
      head_d    = '0;
      tail_d    = '0;
      fill_d    = '0;
      count_d   = '0;
      pending_d = '0;
      filled_d  = '0;
      discard_d = discard_q + pending_q
                  - ((imem_rvalid_i && has_target) ? CW'(1) : CW'(0));
    end else begin
      if (drop) discard_d = discard_q - CW'(1);
      if (fill) begin
        einstr_d[fill_q] = imem_rdata_i;
        filled_d[fill_q] = 1'b1;
        fill_d           = fill_q + AW'(1);
      end
      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + AW'(1);
      end
      if (alloc) begin
        epc_d[tail_q]    = pc_q;
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + AW'(1);
        pc_d             = pc_q + XLEN'(4);
      end
      count_d   = count_q + CW'(alloc) - CW'(pop);
      pending_d = pending_q + CW'(alloc) - CW'(fill);
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      head_q    <= '0;
      tail_q    <= '0;
      fill_q    <= '0;
      count_q   <= '0;
      pending_q <= '0;
      discard_q <= '0;
      filled_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        epc_q[i]    <= '0;
        einstr_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      discard_q <= discard_d;
      filled_q  <= filled_d;
      epc_q     <= epc_d;
      einstr_q  <= einstr_d;
    end
  end

  // Protocol checks: a response needs an owner, and stale responses stay bounded.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      assert (!(imem_rvalid_i && !has_target));
      assert (discard_d <= CW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. Expected {pc, instr} pairs
// are pushed from an independent fetch-address model when a grant happens,
// flushed on redirect, and popped/compared when ID accepts an entry.
module tb_fetch_unit;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        id_valid_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;
  logic [2:0]  count_o;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i), .id_valid_o(id_valid_o),
    .id_ready_i(id_ready_i), .id_pc_o(id_pc_o), .id_instr_o(id_instr_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] addr; int due; } req_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          gnt_rand = 1'b0;
  logic [31:0] next_addr = RESET_PC;
  req_t        inflight[$];
  logic [31:0] exp_pc[$];
  logic [31:0] exp_instr[$];
  logic [31:0] grant_log[$];
  logic [31:0] pop_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bookkeeping on the falling edge: consume ID pops, then apply redirect/grant.
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (id_valid_o && id_ready_i) begin
        check_eq("sb_has_entry", exp_pc.size() > 0, 1'b1);
        if (exp_pc.size() > 0) begin
          check_eq("pop_pc", id_pc_o, exp_pc.pop_front());
          check_eq("pop_instr", id_instr_o, exp_instr.pop_front());
        end
        pop_log.push_back(id_pc_o);
        $display("pop  pc=%08h instr=%08h count=%0d", id_pc_o, id_instr_o, count_o);
      end
      if (redirect_i) begin
        check_eq("no_req_on_redirect", imem_req_o, 1'b0);
        exp_pc.delete();
        exp_instr.delete();
        next_addr = {redirect_pc_i[31:2], 2'b00};
        $display("redir pc=%08h", next_addr);
      end else if (imem_req_o && imem_gnt_i) begin
        check_eq("grant_addr", imem_addr_o, next_addr);
        exp_pc.push_back(next_addr);
        exp_instr.push_back(mem_word(next_addr));
        next_addr = next_addr + 32'd4;
      end
      if (imem_req_o && imem_gnt_i) begin
        inflight.push_back('{addr: imem_addr_o, due: cyc + lat});
        grant_log.push_back(imem_addr_o);
        $display("grant addr=%08h", imem_addr_o);
      end
    end
  end

  // Memory model: in-order responses after the configured latency.
  always @(posedge clk_i) begin
    cyc++;
    #1;
    imem_rvalid_i = 1'b0;
    if (rst_i && inflight.size() > 0 && inflight[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(inflight[0].addr);
      void'(inflight.pop_front());
    end
    if (gnt_rand) imem_gnt_i = 1'($urandom_range(0, 1));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},   imem_req_o, 1'b0);
    check_eq({tag, "_addr"},  imem_addr_o, RESET_PC);
    check_eq({tag, "_valid"}, id_valid_o, 1'b0);
    check_eq({tag, "_count"}, count_o, 3'd0);
    check_eq({tag, "_idpc"},  id_pc_o, 32'd0);
    check_eq({tag, "_instr"}, id_instr_o, 32'd0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs are checked before any edge.
  task automatic do_reset(input string tag);
    @(negedge clk_i);
    #2;
    rst_i = 1'b0;
    gnt_rand = 1'b0;
    start_i = 1'b0;
    redirect_i = 1'b0;
    id_ready_i = 1'b0;
    imem_gnt_i = 1'b0;
    inflight.delete();
    exp_pc.delete();
    exp_instr.delete();
    grant_log.delete();
    pop_log.delete();
    next_addr = RESET_PC;
    #1;
    check_reset_outputs(tag);
    tick(2);
    rst_i = 1'b1;
  endtask

  task automatic wait_pops(input int n, input int budget, input string tag);
    int k = 0;
    while (pop_log.size() < n && k < budget) begin
      @(posedge clk_i);
      k++;
    end
    #1;
    check_eq({tag, "_pops_seen"}, pop_log.size() >= n, 1'b1);
  endtask

  task automatic wait_grants(input int n, input int budget, input string tag);
    int k = 0;
    while (grant_log.size() < n && k < budget) begin
      @(posedge clk_i);
      k++;
    end
    #1;
    check_eq({tag, "_grants_seen"}, grant_log.size() >= n, 1'b1);
  endtask

  task automatic drain(input int budget, input string tag);
    int k = 0;
    start_i = 1'b0;
    id_ready_i = 1'b1;
    redirect_i = 1'b0;
    while (count_o != 3'd0 && k < budget) begin
      tick(1);
      k++;
    end
    check_eq({tag, "_count_zero"}, count_o, 3'd0);
    check_eq({tag, "_sb_empty"}, exp_pc.size(), 0);
  endtask

  initial begin
    // Streaming: one fetch per cycle, in order.
    do_reset("t1_rst");
    lat = 1; imem_gnt_i = 1'b1; id_ready_i = 1'b1; start_i = 1'b1;
    tick(30);
    check_eq("t1_throughput", pop_log.size() >= 25, 1'b1);
    check_eq("t1_pc0", pop_log[0], 32'h0);
    check_eq("t1_pc1", pop_log[1], 32'h4);
    check_eq("t1_pc2", pop_log[2], 32'h8);
    drain(20, "t1");
    check_eq("t1_idle_req", imem_req_o, 1'b0);

    // Stalled ID: queue fills to DEPTH, then drains in order and fetch resumes.
    do_reset("t2_rst");
    lat = 1; imem_gnt_i = 1'b1; id_ready_i = 1'b0; start_i = 1'b1;
    tick(10);
    check_eq("t2_grants", grant_log.size(), DEPTH);
    check_eq("t2_count_full", count_o, 3'd4);
    check_eq("t2_req_full", imem_req_o, 1'b0);
    check_eq("t2_head_valid", id_valid_o, 1'b1);
    id_ready_i = 1'b1;
    wait_pops(8, 30, "t2");
    check_eq("t2_pop0", pop_log[0], 32'h0);
    check_eq("t2_pop1", pop_log[1], 32'h4);
    check_eq("t2_pop2", pop_log[2], 32'h8);
    check_eq("t2_pop3", pop_log[3], 32'hC);
    check_eq("t2_resume", grant_log[4], 32'h10);
    drain(20, "t2");

    // Redirect with three requests in flight; target given unaligned.
    do_reset("t3_rst");
    lat = 3; imem_gnt_i = 1'b1; id_ready_i = 1'b1; start_i = 1'b1;
    wait_grants(3, 20, "t3");
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0106;
    @(negedge clk_i);
    check_eq("t3_redir_req", imem_req_o, 1'b0);
    check_eq("t3_redir_count_before", count_o, 3'd3);
    tick(1);
    redirect_i = 1'b0;
    @(negedge clk_i);
    check_eq("t3_count_cleared", count_o, 3'd0);
    check_eq("t3_valid_cleared", id_valid_o, 1'b0);
    wait_pops(3, 40, "t3");
    check_eq("t3_first_pc", pop_log[0], 32'h104);
    check_eq("t3_second_pc", pop_log[1], 32'h108);
    drain(30, "t3");

    // Redirect with an rvalid in the same cycle, a filled head offered to ID.
    do_reset("t4_rst");
    lat = 2; imem_gnt_i = 1'b1; id_ready_i = 1'b1; start_i = 1'b1;
    wait_grants(3, 20, "t4");
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
    @(negedge clk_i);
    check_eq("t5_valid_masked", id_valid_o, 1'b0);
    check_eq("t5_head_filled_pc", id_pc_o, 32'h0);
    check_eq("t4_count_before", count_o, 3'd3);
    tick(1);
    redirect_i = 1'b0;
    @(negedge clk_i);
    check_eq("t4_count_cleared", count_o, 3'd0);
    wait_pops(2, 40, "t4");
    check_eq("t4_first_pc", pop_log[0], 32'h200);
    check_eq("t4_second_pc", pop_log[1], 32'h204);
    drain(30, "t4");

    // PC wrap at the top of the address space, then reset mid-stream.
    do_reset("t6_rst");
    lat = 1; imem_gnt_i = 1'b1; id_ready_i = 1'b1;
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
    tick(1);
    redirect_i = 1'b0; start_i = 1'b1;
    wait_grants(4, 20, "t6");
    check_eq("t6_g0", grant_log[0], 32'hFFFF_FFF8);
    check_eq("t6_g1", grant_log[1], 32'hFFFF_FFFC);
    check_eq("t6_wrap", grant_log[2], 32'h0);
    check_eq("t6_g3", grant_log[3], 32'h4);
    wait_pops(3, 20, "t6");
    check_eq("t6_pop_wrap", pop_log[2], 32'h0);
    do_reset("t6_midrst");

    // Random grant/ready traffic with periodic unaligned redirects.
    lat = 2; gnt_rand = 1'b1; start_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      id_ready_i = 1'($urandom_range(0, 1));
      if (i % 40 == 20) begin
        redirect_i = 1'b1;
        redirect_pc_i = $urandom & 32'h0000_FFFF;
      end else begin
        redirect_i = 1'b0;
      end
      tick(1);
    end
    redirect_i = 1'b0;
    gnt_rand = 1'b0;
    tick(1);
    imem_gnt_i = 1'b1;
    drain(40, "t7");
    check_eq("t7_activity", pop_log.size() >= 50, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
